// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 sensor emulator: qualifies a trig pulse, waits a fixed burst delay, then
// drives echo high for a programmable number of microseconds.
module ultrasonic_echo_responder #(
    parameter int unsigned CLK_PER_US  = 40,
    parameter int unsigned MIN_TRIG_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLDOFF_US  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        trig_i,
    input  logic [15:0] echo_us_i,
    output logic        echo_o,
    output logic        busy_o,
    output logic        err_short_o
);

    localparam int unsigned MinCyc = MIN_TRIG_US * CLK_PER_US;
    localparam int unsigned PreW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int unsigned CycW   = $clog2(MinCyc + 1);

    localparam logic [PreW-1:0] PreMax    = PreW'(CLK_PER_US - 1);
    localparam logic [CycW-1:0] CycMax    = CycW'(MinCyc);
    localparam logic [15:0]     BurstLast = 16'(BURST_US - 1);
    localparam logic [15:0]     HoldLast  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]     Timeout   = 16'(TIMEOUT_US);

    typedef enum logic [2:0] {
        StIdle,
        StTrigHi,
        StBurst,
        StEcho,
        StHoldoff
    } state_e;

    state_e            state_q;
    logic              trig_meta_q, trig_s_q, trig_d1_q;
    logic [PreW-1:0]   presc_q;
    logic [15:0]       us_cnt_q;
    logic [CycW-1:0]   cyc_q;
    logic [15:0]       w_q;
    logic              echo_q;
    logic              err_q;

    logic              trig_rise;
    logic              us_tick;
    logic [15:0]       us_last;
    logic              timer_done;

    assign trig_rise = trig_s_q & ~trig_d1_q;
    assign us_tick   = (presc_q == PreMax);

    always_comb begin
        us_last = '0;
        unique case (state_q)
            StBurst:   us_last = BurstLast;
            StEcho:    us_last = w_q - 16'd1;
            StHoldoff: us_last = HoldLast;
            default:   us_last = '0;
        endcase
    end

    assign timer_done = us_tick && (us_cnt_q == us_last);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            trig_meta_q <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_d1_q   <= 1'b0;
            presc_q     <= '0;
            us_cnt_q    <= '0;
            cyc_q       <= '0;
            w_q         <= '0;
            echo_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            trig_meta_q <= trig_i;
            trig_s_q    <= trig_meta_q;
            trig_d1_q   <= trig_s_q;
            err_q       <= 1'b0;

            if (us_tick) begin
                presc_q  <= '0;
                us_cnt_q <= us_cnt_q + 16'd1;
            end else begin
                presc_q  <= presc_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (trig_rise) begin
                        state_q  <= StTrigHi;
                        // The rise cycle itself is the first counted high cycle.
                        cyc_q    <= CycW'(1);
                        presc_q  <= '0;
                        us_cnt_q <= '0;
                    end
                end
                StTrigHi: begin
                    if (trig_s_q) begin
                        if (cyc_q != CycMax) begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end else if (cyc_q >= CycMax) begin
                        state_q  <= StBurst;
                        w_q      <= (echo_us_i == 16'd0) ? Timeout : echo_us_i;
                        presc_q  <= '0;
                        us_cnt_q <= '0;
                    end else begin
                        state_q  <= StIdle;
                        err_q    <= 1'b1;
                        presc_q  <= '0;
                        us_cnt_q <= '0;
                    end
                end
                StBurst: begin
                    if (timer_done) begin
                        state_q  <= StEcho;
                        echo_q   <= 1'b1;
                        presc_q  <= '0;
                        us_cnt_q <= '0;
                    end
                end
                StEcho: begin
                    if (timer_done) begin
                        state_q  <= StHoldoff;
                        echo_q   <= 1'b0;
                        presc_q  <= '0;
                        us_cnt_q <= '0;
                    end
                end
                StHoldoff: begin
                    if (timer_done) begin
                        state_q  <= StIdle;
                        presc_q  <= '0;
                        us_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    echo_q  <= 1'b0;
                end
            endcase
        end
    end

    assign echo_o      = echo_q;
    assign busy_o      = (state_q != StIdle);
    assign err_short_o = err_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Randomised bench for ultrasonic_echo_responder with scaled-down timing parameters.
module tb_ultrasonic_echo_responder;

    localparam int C    = 4;
    localparam int MINU = 10;
    localparam int BU   = 20;
    localparam int TO   = 500;
    localparam int HU   = 10;

    localparam int MIN_CYC  = MINU * C;
    localparam int BC       = BU * C;
    localparam int LAT_LIM  = BC + 30;
    localparam int HI_LIM   = TO * C + 500;
    localparam int HOLD_LIM = HU * C + 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig = 1'b0;
    logic [15:0] echo_us = 16'd0;
    logic        echo, busy, err_short;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int echo_cyc = 0;
    int echo_rises = 0;
    logic echo_prev = 1'b0;

    ultrasonic_echo_responder #(
        .CLK_PER_US (C),
        .MIN_TRIG_US(MINU),
        .BURST_US   (BU),
        .TIMEOUT_US (TO),
        .HOLDOFF_US (HU)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .trig_i     (trig),
        .echo_us_i  (echo_us),
        .echo_o     (echo),
        .busy_o     (busy),
        .err_short_o(err_short)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_short === 1'b1) err_cnt++;
        if (err_short === 1'b1 && echo === 1'b1) overlap_cnt++;
        if (echo === 1'b1) echo_cyc++;
        if (echo === 1'b1 && echo_prev !== 1'b1) echo_rises++;
        echo_prev = echo;
    end

    // Reference: a trig of w cycles is accepted iff w >= MIN_TRIG_US*CLK_PER_US.
    function automatic int exp_width(input int e, input int w);
        if (w < MIN_CYC) return 0;
        return ((e == 0) ? TO : e) * C;
    endfunction

    task automatic pulse_trig(input int w);
        @(negedge clk);
        trig = 1'b1;
        repeat (w) @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic measure(output int lat, output int hi, output int hold);
        lat = 0;
        while (echo !== 1'b1 && lat < LAT_LIM) begin
            @(negedge clk);
            lat++;
        end
        hi = 0;
        while (echo === 1'b1 && hi < HI_LIM) begin
            @(negedge clk);
            hi++;
        end
        hold = 0;
        while (busy === 1'b1 && hold < HOLD_LIM) begin
            @(negedge clk);
            hold++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < HI_LIM + LAT_LIM) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo got %b want 0", echo); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (err_short !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_short); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_valid(input int iters);
        int lat, hi, hold, w, e, e0;
        for (int i = 0; i < iters; i++) begin
            w = (i == 0) ? MIN_CYC : MIN_CYC + int'($urandom_range(1, 60));
            e = int'($urandom_range(1, 120));
            echo_us = 16'(e);
            e0 = err_cnt;
            pulse_trig(w);
            measure(lat, hi, hold);
            checks++;
            if (lat < BC + 2 || lat > BC + 4) begin
                errors++; $display("FAIL valid_latency got %0d want %0d+-1", lat, BC + 3);
            end
            checks++;
            if (hi !== exp_width(e, w)) begin
                errors++; $display("FAIL valid_width got %0d want %0d", hi, exp_width(e, w));
            end
            checks++;
            if (hold !== HU * C) begin
                errors++; $display("FAIL valid_holdoff got %0d want %0d", hold, HU * C);
            end
            checks++;
            if (err_cnt - e0 !== 0) begin
                errors++; $display("FAIL valid_no_err got %0d want 0", err_cnt - e0);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_short(input int iters);
        int w, e0, r0;
        for (int i = 0; i < iters; i++) begin
            w = (i == 0) ? MIN_CYC - 1 : int'($urandom_range(1, MIN_CYC - 2));
            echo_us = 16'($urandom_range(1, 100));
            e0 = err_cnt;
            r0 = echo_rises;
            pulse_trig(w);
            repeat (BC + 20) @(negedge clk);
            checks++;
            if (err_cnt - e0 !== 1) begin
                errors++; $display("FAIL short_err_cycles got %0d want 1 (w=%0d)", err_cnt - e0, w);
            end
            checks++;
            if (echo_rises - r0 !== exp_width(1, w)) begin
                errors++; $display("FAIL short_no_echo got %0d rises want 0", echo_rises - r0);
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got %b want 0", busy); end
        end
    endtask

    task automatic test_timeout();
        int lat, hi, hold;
        echo_us = 16'd0;
        pulse_trig(MIN_CYC + 8);
        measure(lat, hi, hold);
        checks++;
        if (hi !== exp_width(0, MIN_CYC + 8)) begin
            errors++; $display("FAIL timeout_width got %0d want %0d", hi, TO * C);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latch_ignore();
        int r0, c0, e0, n, e;
        e = int'($urandom_range(100, 200));
        echo_us = 16'(e);
        r0 = echo_rises;
        c0 = echo_cyc;
        e0 = err_cnt;
        pulse_trig(MIN_CYC + 20);
        n = 0;
        while (echo !== 1'b1 && n < LAT_LIM) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        echo_us = 16'd5;
        pulse_trig(MIN_CYC + 20);
        wait_idle();
        repeat (BC + 60) @(negedge clk);
        checks++;
        if (echo_rises - r0 !== 1) begin
            errors++; $display("FAIL latch_pulses got %0d want 1", echo_rises - r0);
        end
        checks++;
        if (echo_cyc - c0 !== e * C) begin
            errors++; $display("FAIL latch_width got %0d want %0d", echo_cyc - c0, e * C);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++; $display("FAIL latch_no_err got %0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_holdoff_trig();
        int r0, e0, n;
        echo_us = 16'($urandom_range(1, 50));
        r0 = echo_rises;
        e0 = err_cnt;
        pulse_trig(MIN_CYC + 4);
        n = 0;
        while (echo !== 1'b1 && n < LAT_LIM) begin @(negedge clk); n++; end
        n = 0;
        while (echo === 1'b1 && n < HI_LIM) begin @(negedge clk); n++; end
        repeat (int'($urandom_range(1, HU * C - 10))) @(negedge clk);
        pulse_trig(HU * C + 100);
        repeat (BC + 60) @(negedge clk);
        checks++;
        if (echo_rises - r0 !== 1) begin
            errors++; $display("FAIL holdoff_trig_pulses got %0d want 1", echo_rises - r0);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++; $display("FAIL holdoff_trig_err got %0d want 0", err_cnt - e0);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL holdoff_trig_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n, lat, hi, hold;
        echo_us = 16'd100;
        pulse_trig(MIN_CYC + 10);
        n = 0;
        while (echo !== 1'b1 && n < LAT_LIM) begin @(negedge clk); n++; end
        repeat (100) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (echo !== 1'b0) begin errors++; $display("FAIL midreset_echo got %b want 0", echo); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        echo_us = 16'd30;
        pulse_trig(MIN_CYC);
        measure(lat, hi, hold);
        checks++;
        if (hi !== exp_width(30, MIN_CYC)) begin
            errors++; $display("FAIL midreset_next_width got %0d want %0d", hi, 30 * C);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_long_trig();
        int c0, lat, hi, hold;
        echo_us = 16'd20;
        c0 = echo_cyc;
        pulse_trig(1000 + int'($urandom_range(0, 200)));
        checks++;
        if (echo_cyc - c0 !== 0) begin
            errors++; $display("FAIL long_trig_early_echo got %0d cycles want 0", echo_cyc - c0);
        end
        measure(lat, hi, hold);
        checks++;
        if (lat < BC + 2 || lat > BC + 4) begin
            errors++; $display("FAIL long_trig_latency got %0d want %0d+-1", lat, BC + 3);
        end
        checks++;
        if (hi !== 20 * C) begin
            errors++; $display("FAIL long_trig_width got %0d want %0d", hi, 20 * C);
        end
    endtask

    initial begin
        test_reset();
        test_valid(4);
        test_short(3);
        test_timeout();
        test_latch_ignore();
        test_holdoff_trig();
        test_reset_mid();
        test_long_trig();
        checks++;
        if (overlap_cnt !== 0) begin
            errors++; $display("FAIL err_with_echo got %0d want 0", overlap_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
